// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared FSM state type, oversampling constants and counter sizing
//            helpers for the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Oversample counter must hold both OVERSAMPLE-1 and SB_TICK-1.
   function automatic int s_cnt_width(input int sb_tick);
      return ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
   endfunction

   function automatic int n_cnt_width(input int dbit);
      return (dbit > 1) ? $clog2(dbit) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for the asynchronous serial line; resets
//            to the idle-high line level so reset never looks like a start bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
      end
   end

   assign q_o = sync2_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampled UART receiver; samples each bit at its middle,
//            flags completion with a one-clock pulse and reports stop errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout,
   output logic            frame_err
);

   localparam int SW = s_cnt_width(SB_TICK);
   localparam int NW = n_cnt_width(DBIT);

   localparam logic [SW-1:0] C_MID_CNT  = SW'(MID_SAMPLE);
   localparam logic [SW-1:0] C_BIT_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] C_STP_LAST = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] C_N_LAST   = NW'(DBIT - 1);

   logic            rx_s;

   uart_state_e     state_q,  state_d;
   logic [SW-1:0]   s_cnt_q,  s_cnt_d;
   logic [NW-1:0]   n_cnt_q,  n_cnt_d;
   logic [DBIT-1:0] b_reg_q,  b_reg_d;
   logic            done_q,   done_d;
   logic            ferr_q,   ferr_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // Start detection ignores s_tick so back-to-back frames lose no cycle.
   always_comb begin
      state_d = state_q;
      s_cnt_d = s_cnt_q;
      n_cnt_d = n_cnt_q;
      b_reg_d = b_reg_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_cnt_d = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_cnt_q == C_MID_CNT) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     s_cnt_d = '0;
                     n_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_cnt_q == C_BIT_LAST) begin
                  s_cnt_d = '0;
                  b_reg_d = {rx_s, b_reg_q[DBIT-1:1]};
                  if (n_cnt_q == C_N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_cnt_d = n_cnt_q + NW'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_cnt_q == C_STP_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  ferr_d  = ~rx_s;
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         b_reg_q <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         b_reg_q <= b_reg_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_done_tick = done_q;
   assign dout         = b_reg_q;
   assign frame_err    = ferr_q;

endmodule

`default_nettype wire
